// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core constants and the thread id type
package mips_core_pkg;
  localparam int NUM_THREADS = 2;
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int PC_STRIDE = 4;
  typedef logic [TID_W-1:0] ThreadId;
endpackage

// File: rtl/thread_fetch_unit_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       last,
  output logic [W-1:0]       grant,
  output logic               grant_valid
);
  logic [W-1:0] idx;
  // scan from the farthest offset down so the nearest requester after last wins
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + W'(k);
      if (req[idx]) begin
        grant = idx;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/thread_fetch_unit.sv
// thread_fetch_unit: per-thread PC table with round-robin fetch selection; THREAD_FETCH_PERF_EN adds per-thread fetch counters
module thread_fetch_unit
  import mips_core_pkg::*;
#(
  parameter int NUM_THREADS = mips_core_pkg::NUM_THREADS,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STRIDE = mips_core_pkg::PC_STRIDE,
  parameter int TW = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic [NUM_THREADS-1:0] i_thread_ready,
  input  logic                   i_redirect_valid,
  input  logic [TW-1:0]          i_redirect_tid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
  output logic                   o_valid,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [TW-1:0]          o_thread_id
`ifdef THREAD_FETCH_PERF_EN
  ,
  output logic [31:0]            o_fetch_count [NUM_THREADS]
`endif
);
  logic [ADDR_WIDTH-1:0]  pc [NUM_THREADS];
  logic [TW-1:0]          last_grant;
  logic [NUM_THREADS-1:0] eligible;
  logic [TW-1:0]          grant;
  logic                   grant_valid;
  // a thread being redirected sits out this cycle so it fetches its target next
  assign eligible = i_thread_ready & ~(i_redirect_valid ? NUM_THREADS'(1) << i_redirect_tid : '0);
  rr_arbiter #(.NUM_REQ(NUM_THREADS), .W(TW)) u_arb (
    .req(eligible),
    .last(last_grant),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc[t] <= RESET_PC;
      last_grant <= TW'(NUM_THREADS - 1);
      o_valid <= 1'b0;
      o_pc <= RESET_PC;
      o_thread_id <= '0;
    end else begin
      if (!i_stall) begin
        o_valid <= grant_valid;
        if (grant_valid) begin
          o_pc <= pc[grant];
          o_thread_id <= grant;
          pc[grant] <= pc[grant] + ADDR_WIDTH'(PC_STRIDE);
          last_grant <= grant;
        end
      end else if (i_redirect_valid && o_valid && o_thread_id == i_redirect_tid) begin
        o_valid <= 1'b0;
      end
      if (i_redirect_valid) pc[i_redirect_tid] <= i_redirect_target;
    end
  end
`ifdef THREAD_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) o_fetch_count[t] <= '0;
    end else if (!i_stall && grant_valid) begin
      o_fetch_count[grant] <= o_fetch_count[grant] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_thread_fetch_unit.sv
// tb_thread_fetch_unit: directed vector table plus randomized run against a reference model
module tb_thread_fetch_unit;
  localparam int NT = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall;
  logic [1:0]  i_thread_ready;
  logic        i_redirect_valid;
  logic [0:0]  i_redirect_tid;
  logic [31:0] i_redirect_target;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [0:0]  o_thread_id;
`ifdef THREAD_FETCH_PERF_EN
  logic [31:0] o_fetch_count [NT];
`endif
  int total = 0;
  int bad = 0;

  thread_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .i_stall(i_stall),
    .i_thread_ready(i_thread_ready),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_tid(i_redirect_tid),
    .i_redirect_target(i_redirect_target),
    .o_valid(o_valid),
    .o_pc(o_pc),
    .o_thread_id(o_thread_id)
`ifdef THREAD_FETCH_PERF_EN
    ,
    .o_fetch_count(o_fetch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  ready;
    logic        rv;
    logic        rtid;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic        etid;
  } vec_t;
  vec_t vt[24];

  task automatic check(input string name, input logic ev, input logic [31:0] epc, input logic etid);
    total++;
    if (o_valid !== ev || o_pc !== epc || o_thread_id !== etid) begin
      bad++;
      $display("FAIL %s: got valid=%0b pc=%h tid=%0d, want valid=%0b pc=%h tid=%0d",
               name, o_valid, o_pc, o_thread_id, ev, epc, etid);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] r, input logic rv, input logic rt, input logic [31:0] tg);
    i_stall = s;
    i_thread_ready = r;
    i_redirect_valid = rv;
    i_redirect_tid = rt;
    i_redirect_target = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 2'b00, 0, 0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] mpc [NT];
  int          mlast;
  logic        mv;
  logic [31:0] mpco;
  logic        mtid;

  task automatic model_step(input logic s, input logic [1:0] r, input logic rv, input logic rt, input logic [31:0] tg);
    bit found;
    int sel;
    found = 0;
    sel = 0;
    if (!s) begin
      for (int off = 1; off <= NT; off++) begin
        int t;
        t = (mlast + off) % NT;
        if (!found && r[t] && !(rv && int'(rt) == t)) begin
          found = 1;
          sel = t;
        end
      end
      mv = found;
      if (found) begin
        mpco = mpc[sel];
        mtid = sel[0];
        mpc[sel] = mpc[sel] + 32'd4;
        mlast = sel;
      end
    end else if (rv && mv && mtid == rt) begin
      mv = 0;
    end
    if (rv) mpc[rt] = tg;
  endtask

  initial begin
    vt[0]  = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h0,        0};
    vt[1]  = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h0,        1};
    vt[2]  = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h4,        0};
    vt[3]  = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h4,        1};
    vt[4]  = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h8,        0};
    vt[5]  = '{0, 2'b10, 0, 0, 32'h0,        1, 32'h8,        1};
    vt[6]  = '{0, 2'b10, 0, 0, 32'h0,        1, 32'hC,        1};
    vt[7]  = '{0, 2'b10, 0, 0, 32'h0,        1, 32'h10,       1};
    vt[8]  = '{0, 2'b01, 0, 0, 32'h0,        1, 32'hC,        0};
    vt[9]  = '{0, 2'b11, 1, 0, 32'h400,      1, 32'h14,       1};
    vt[10] = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h400,      0};
    vt[11] = '{1, 2'b11, 1, 1, 32'h80,       1, 32'h400,      0};
    vt[12] = '{1, 2'b11, 0, 0, 32'h0,        1, 32'h400,      0};
    vt[13] = '{1, 2'b11, 0, 0, 32'h0,        1, 32'h400,      0};
    vt[14] = '{1, 2'b11, 0, 0, 32'h0,        1, 32'h400,      0};
    vt[15] = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h80,       1};
    vt[16] = '{1, 2'b11, 1, 1, 32'h200,      0, 32'h80,       1};
    vt[17] = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h404,      0};
    vt[18] = '{0, 2'b01, 1, 0, 32'hFFFFFFFC, 0, 32'h404,      0};
    vt[19] = '{0, 2'b01, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0};
    vt[20] = '{0, 2'b01, 0, 0, 32'h0,        1, 32'h0,        0};
    vt[21] = '{0, 2'b00, 0, 0, 32'h0,        0, 32'h0,        0};
    vt[22] = '{0, 2'b00, 0, 0, 32'h0,        0, 32'h0,        0};
    vt[23] = '{0, 2'b11, 0, 0, 32'h0,        1, 32'h200,      1};

    do_reset();
    check("reset", 0, 32'h0, 0);
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].stall, vt[i].ready, vt[i].rv, vt[i].rtid, vt[i].tgt);
      tick();
      check($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].etid);
    end

    // reset wins over a simultaneous stall and redirect
    rst = 1'b1;
    drive(1, 2'b11, 1, 1, 32'h999);
    tick();
    rst = 1'b0;
    check("rst_over_stall", 0, 32'h0, 0);
    drive(0, 2'b11, 0, 0, 32'h0);
    tick();
    check("post_rst_t0", 1, 32'h0, 0);
    tick();
    check("post_rst_t1", 1, 32'h0, 1);

    do_reset();
    for (int t = 0; t < NT; t++) mpc[t] = 32'h0;
    mlast = NT - 1;
    mv = 0;
    mpco = 32'h0;
    mtid = 0;
    check("rand_reset", mv, mpco, mtid);
    for (int i = 0; i < 400; i++) begin
      logic s, rv, rt;
      logic [1:0] r;
      logic [31:0] tg;
      s = ($urandom_range(0, 3) == 0);
      r = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) == 0);
      rt = 1'($urandom_range(0, 1));
      tg = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      drive(s, r, rv, rt, tg);
      model_step(s, r, rv, rt, tg);
      tick();
      check($sformatf("rand%0d", i), mv, mpco, mtid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
